// File: rtl/param_shift_engine.sv
// Multi-cycle N-bit shift/rotate engine with a start/busy/done handshake.
// It steps one bit position per clock and has serial in/out for chaining.
module param_shift_engine #(
    parameter int N  = 8,
    parameter int AW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [AW-1:0] amt,
    input  logic [N-1:0]  din,
    input  logic          sin,
    input  logic          abort,
    output logic [N-1:0]  dout,
    output logic          sout,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_SLL  = 3'b010,
        OP_SRL  = 3'b011,
        OP_SRA  = 3'b100,
        OP_ROL  = 3'b101,
        OP_ROR  = 3'b110,
        OP_CLR  = 3'b111
    } op_t;

    state_t        state_q;
    op_t           op_q;
    op_t           op_in;
    logic [AW-1:0] cnt_q;
    logic [N-1:0]  dout_q;
    logic          sout_q;
    logic [N-1:0]  step_dout_d;
    logic          step_sout_d;

    assign op_in = op_t'(op);

    // One step of the latched operation; sin is taken live on every step.
    always_comb begin
        step_dout_d = dout_q;
        step_sout_d = sout_q;
        case (op_q)
            OP_SLL: begin
                step_dout_d = {dout_q[N-2:0], sin};
                step_sout_d = dout_q[N-1];
            end
            OP_SRL: begin
                step_dout_d = {sin, dout_q[N-1:1]};
                step_sout_d = dout_q[0];
            end
            OP_SRA: begin
                step_dout_d = {dout_q[N-1], dout_q[N-1:1]};
                step_sout_d = dout_q[0];
            end
            OP_ROL: begin
                step_dout_d = {dout_q[N-2:0], dout_q[N-1]};
                step_sout_d = dout_q[N-1];
            end
            OP_ROR: begin
                step_dout_d = {dout_q[0], dout_q[N-1:1]};
                step_sout_d = dout_q[0];
            end
            default: begin
                step_dout_d = dout_q;
                step_sout_d = sout_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            cnt_q   <= '0;
            dout_q  <= '0;
            sout_q  <= 1'b0;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    // Abort takes priority over stepping and over any new start.
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else begin
                        dout_q <= step_dout_d;
                        sout_q <= step_sout_d;
                        cnt_q  <= cnt_q - 1'b1;
                        if (cnt_q == AW'(1)) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        op_q <= op_in;
                        case (op_in)
                            OP_NOP:  state_q <= S_DONE;
                            OP_LOAD: begin
                                dout_q  <= din;
                                state_q <= S_DONE;
                            end
                            OP_CLR: begin
                                dout_q  <= '0;
                                state_q <= S_DONE;
                            end
                            default: begin
                                if (amt == '0) begin
                                    state_q <= S_DONE;
                                end else begin
                                    cnt_q   <= amt;
                                    state_q <= S_SHIFT;
                                end
                            end
                        endcase
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign dout = dout_q;
    assign sout = sout_q;
    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_param_shift_engine.sv
// Bench for param_shift_engine (N=8): a step-count model checked on every
// negative edge, plus directed scenarios pinned by literal expectations.
module tb_param_shift_engine;

    localparam int N  = 8;
    localparam int AW = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    op    = 3'b000;
    logic [AW-1:0] amt   = '0;
    logic [N-1:0]  din   = '0;
    logic          sin   = 1'b0;
    logic          abort = 1'b0;
    logic [N-1:0]  dout;
    logic          sout;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    param_shift_engine #(.N(N), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .amt   (amt),
        .din   (din),
        .sin   (sin),
        .abort (abort),
        .dout  (dout),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: register value, last bit out, steps still owed, done flag.
    int m_dout = 0, m_sout = 0, m_left = 0, m_done = 0, m_op = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dout = 0; m_sout = 0; m_left = 0; m_done = 0; m_op = 0;
        end else if (m_left > 0) begin
            m_done = 0;
            if (abort) begin
                m_left = 0;
            end else begin
                case (m_op)
                    2: begin m_sout = m_dout / 128; m_dout = (m_dout * 2 + int'(sin)) % 256; end
                    3: begin m_sout = m_dout % 2;   m_dout = m_dout / 2 + int'(sin) * 128; end
                    4: begin m_sout = m_dout % 2;   m_dout = m_dout / 2 + (m_dout / 128) * 128; end
                    5: begin m_sout = m_dout / 128; m_dout = (m_dout * 2) % 256 + m_dout / 128; end
                    6: begin m_sout = m_dout % 2;   m_dout = m_dout / 2 + (m_dout % 2) * 128; end
                    default: ;
                endcase
                m_left = m_left - 1;
                if (m_left == 0) m_done = 1;
            end
        end else begin
            m_done = 0;
            if (start) begin
                m_op = int'(op);
                case (m_op)
                    0: m_done = 1;
                    1: begin m_dout = int'(din); m_done = 1; end
                    7: begin m_dout = 0; m_done = 1; end
                    default: begin
                        if (int'(amt) == 0) m_done = 1;
                        else m_left = int'(amt);
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        chk("dout", int'(dout), m_dout);
        chk("sout", int'(sout), m_sout);
        chk("busy", int'(busy), (m_left > 0) ? 1 : 0);
        chk("done", int'(done), m_done);
    end

    task automatic wait_done(output int nbusy);
        bit seen;
        seen  = 0;
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) nbusy++;
        end
        chk("done_timeout", int'(seen), 1);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [AW-1:0] a,
                          input logic [N-1:0] d, input int exp_busy, input string name);
        int nb;
        @(posedge clk); #2;
        start = 1'b1; op = o; amt = a; din = d;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(nb);
        chk({name, "_busy_cycles"}, nb, exp_busy);
    endtask

    initial begin
        int nb;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_dout", int'(dout), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sout", int'(sout), 0);
        rst_n = 1'b1;

        run_op(3'b001, 4'd0, 8'hA5, 0, "load");
        chk("load_dout", int'(dout), 8'hA5);

        run_op(3'b001, 4'd0, 8'h81, 0, "load81");
        run_op(3'b100, 4'd3, 8'h00, 3, "sra3");
        chk("sra3_dout", int'(dout), 8'hF0);
        chk("sra3_sout", int'(sout), 0);

        run_op(3'b001, 4'd0, 8'h81, 0, "load81b");
        run_op(3'b101, 4'd9, 8'h00, 9, "rol9");
        chk("rol9_dout", int'(dout), 8'h03);
        chk("rol9_sout", int'(sout), 1);

        run_op(3'b011, 4'd0, 8'h00, 0, "srl0");
        chk("srl0_dout", int'(dout), 8'h03);
        run_op(3'b000, 4'd5, 8'hFF, 0, "nop");
        run_op(3'b111, 4'd0, 8'h00, 0, "clr");
        chk("clr_dout", int'(dout), 0);

        // SLL by 8 with alternating sin and a spurious start mid-run
        @(posedge clk); #2;
        start = 1'b1; op = 3'b010; amt = 4'd8;
        @(posedge clk); #2;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sin = (i % 2 == 0);
            if (i == 3) begin start = 1'b1; op = 3'b001; din = 8'hFF; end
            if (i == 4) start = 1'b0;
            @(posedge clk); #2;
        end
        sin = 1'b0;
        @(negedge clk);
        chk("sll8_done", int'(done), 1);
        chk("sll8_dout", int'(dout), 8'hAA);

        // SRL by 5 on FF, aborted after two steps with start also high
        run_op(3'b001, 4'd0, 8'hFF, 0, "loadff");
        @(posedge clk); #2;
        start = 1'b1; op = 3'b011; amt = 4'd5;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", int'(done), 0);
            chk("abort_idle", int'(busy), 0);
        end
        chk("abort_dout", int'(dout), 8'h3F);

        // Back-to-back: start held through the DONE cycle
        @(posedge clk); #2;
        start = 1'b1; op = 3'b001; din = 8'h3C;
        @(posedge clk); #2;
        op = 3'b110; amt = 4'd2;
        @(posedge clk); #2;
        start = 1'b0;
        @(negedge clk);
        chk("b2b_busy", int'(busy), 1);
        wait_done(nb);
        chk("b2b_busy_cycles", nb + 1, 2);
        chk("b2b_dout", int'(dout), 8'h0F);
        chk("b2b_sout", int'(sout), 0);

        // Reset asserted mid-shift
        @(posedge clk); #2;
        start = 1'b1; op = 3'b010; amt = 4'd7; sin = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_dout", int'(dout), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        sin = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("post_rst_idle", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
